// File: rtl/i2c_sensor_poller_if.sv
// Command/FIFO link between the sensor poller and the I2C master core.
interface i2c_sensor_poller_if;
  logic       receive_send_n;
  logic [7:0] read_count;
  logic       start_process;
  logic       busy;
  logic       fifo_write;
  logic [7:0] tx_data;
  logic       fifo_read_next;
  logic [7:0] rx_data;
  logic       error;

  modport master (
    output receive_send_n,
    output read_count,
    output start_process,
    output fifo_write,
    output tx_data,
    output fifo_read_next,
    input  busy,
    input  rx_data,
    input  error
  );

  modport slave (
    input  receive_send_n,
    input  read_count,
    input  start_process,
    input  fifo_write,
    input  tx_data,
    input  fifo_read_next,
    output busy,
    output rx_data,
    output error
  );
endinterface

// File: rtl/i2c_sensor_poller.sv
// Periodic one-shot I2C sensor acquisition with change-threshold interrupt.
// Define I2C_SENSOR_POLLER_RETRY_EN to retry failed transactions RETRY_MAX times.
module i2c_sensor_poller #(
  parameter int         DATA_BYTES = 2,
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter logic [7:0] CFG_REG    = 8'h03,
  parameter logic [7:0] CFG_VAL    = 8'h20,
  parameter logic [7:0] DATA_REG   = 8'h00
`ifdef I2C_SENSOR_POLLER_RETRY_EN
  ,
  parameter int         RETRY_MAX  = 2
`endif
) (
  input  logic                      Clk_i,
  input  logic                      Reset_i,
  input  logic                      Enable_i,
  i2c_sensor_poller_if.master       i2c,
  input  logic [15:0]               PeriodCounterPresetH_i,
  input  logic [15:0]               PeriodCounterPresetL_i,
  input  logic [15:0]               WaitCounterPresetH_i,
  input  logic [15:0]               WaitCounterPresetL_i,
  input  logic [8*DATA_BYTES-1:0]   Threshold_i,
  output logic [8*DATA_BYTES-1:0]   SensorValue_o,
  output logic                      CpuIntr_o,
  output logic                      ErrIntr_o
);

  localparam int         VW        = 8 * DATA_BYTES;
  localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    PERIOD_WAIT,
    CFG_LOAD,
    CFG_START,
    CFG_BUSY,
    CONV_WAIT,
    RD_LOAD,
    RD_START,
    RD_BUSY,
    RD_FETCH,
    COMPARE,
    ERR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [31:0]   cnt;
  logic [1:0]    idx;
  logic          first;
  logic          abort;
  logic          cpu_q;
  logic [VW-1:0] sample;
  logic [VW-1:0] diff;
  logic          stop;
  logic          done;
  logic          can_retry;

  logic          fifo_write;
  logic [7:0]    tx_data;
  logic          start_process;
  logic          receive_send_n;
  logic [7:0]    read_count;
  logic          fifo_read_next;
  logic          err_pulse;

`ifdef I2C_SENSOR_POLLER_RETRY_EN
  logic [1:0] retry;

  assign can_retry = int'(retry) < RETRY_MAX;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      retry <= 2'd0;
    end else if (state == PERIOD_WAIT && state_n == CFG_LOAD) begin
      retry <= 2'd0;
    end else if ((state == CFG_BUSY && state_n == CFG_LOAD) ||
                 (state == RD_BUSY && state_n == RD_LOAD)) begin
      retry <= retry + 2'd1;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  // a dropped enable is latched so the running transaction still completes
  assign stop = abort | ~Enable_i;
  assign done = ~first & ~i2c.busy;
  assign diff = (sample >= SensorValue_o) ? sample - SensorValue_o
                                          : SensorValue_o - sample;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (Enable_i) state_n = PERIOD_WAIT;
      end
      PERIOD_WAIT: begin
        if (!Enable_i)      state_n = IDLE;
        else if (cnt == '0) state_n = CFG_LOAD;
      end
      CFG_LOAD: begin
        if (idx == 2'd2) state_n = CFG_START;
      end
      CFG_START: state_n = CFG_BUSY;
      CFG_BUSY: begin
        if (done) begin
          if (stop)           state_n = IDLE;
          else if (!i2c.error) state_n = CONV_WAIT;
          else if (can_retry) state_n = CFG_LOAD;
          else                state_n = ERR;
        end
      end
      CONV_WAIT: begin
        if (!Enable_i)      state_n = IDLE;
        else if (cnt == '0) state_n = RD_LOAD;
      end
      RD_LOAD: begin
        if (idx == 2'd2) state_n = RD_START;
      end
      RD_START: state_n = RD_BUSY;
      RD_BUSY: begin
        if (done) begin
          if (!i2c.error)     state_n = RD_FETCH;
          else if (stop)      state_n = IDLE;
          else if (can_retry) state_n = RD_LOAD;
          else                state_n = ERR;
        end
      end
      RD_FETCH: begin
        if (idx == LAST_BYTE) state_n = stop ? IDLE : COMPARE;
      end
      COMPARE: state_n = PERIOD_WAIT;
      ERR:     state_n = PERIOD_WAIT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fifo_write     = 1'b0;
    tx_data        = 8'h00;
    start_process  = 1'b0;
    receive_send_n = 1'b0;
    read_count     = 8'h00;
    fifo_read_next = 1'b0;
    err_pulse      = 1'b0;
    if (!Reset_i) begin
      unique case (state)
        CFG_LOAD, RD_LOAD: begin
          fifo_write = 1'b1;
          unique case (idx)
            2'd0:    tx_data = {DEV_ADDR, 1'b0};
            2'd1:    tx_data = (state == CFG_LOAD) ? CFG_REG : DATA_REG;
            default: tx_data = (state == CFG_LOAD) ? CFG_VAL
                                                   : {DEV_ADDR, 1'b1};
          endcase
        end
        CFG_START: start_process = 1'b1;
        RD_START, RD_BUSY: begin
          start_process  = (state == RD_START);
          receive_send_n = 1'b1;
          read_count     = 8'(DATA_BYTES);
        end
        RD_FETCH: fifo_read_next = 1'b1;
        ERR:      err_pulse      = 1'b1;
        default: ;
      endcase
    end
  end

  assign i2c.fifo_write     = fifo_write;
  assign i2c.tx_data        = tx_data;
  assign i2c.start_process  = start_process;
  assign i2c.receive_send_n = receive_send_n;
  assign i2c.read_count     = read_count;
  assign i2c.fifo_read_next = fifo_read_next;
  assign ErrIntr_o          = err_pulse;
  assign CpuIntr_o          = cpu_q & ~Reset_i;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      cnt           <= '0;
      idx           <= 2'd0;
      first         <= 1'b0;
      abort         <= 1'b0;
      cpu_q         <= 1'b0;
      sample        <= '0;
      SensorValue_o <= '0;
    end else begin
      cpu_q <= 1'b0;
      first <= (state == CFG_START) || (state == RD_START);
      abort <= stop && (state_n inside {CFG_LOAD, CFG_START, CFG_BUSY,
                                        RD_LOAD, RD_START, RD_BUSY,
                                        RD_FETCH});
      idx   <= (state_n == state) ? idx + 2'd1 : 2'd0;
      if (state_n != state && state_n == PERIOD_WAIT) begin
        cnt <= {PeriodCounterPresetH_i, PeriodCounterPresetL_i};
      end else if (state_n != state && state_n == CONV_WAIT) begin
        cnt <= {WaitCounterPresetH_i, WaitCounterPresetL_i};
      end else if (cnt != '0) begin
        cnt <= cnt - 32'd1;
      end
      if (state == RD_FETCH) begin
        sample[8*(DATA_BYTES-1-int'(idx)) +: 8] <= i2c.rx_data;
      end
      if (state == COMPARE && diff > Threshold_i) begin
        SensorValue_o <= sample;
        cpu_q         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Randomised bench for i2c_sensor_poller: 2-byte and 3-byte instances
// driven by a behavioural I2C master core and a threshold reference.
module tb_i2c_sensor_poller;

`ifdef I2C_SENSOR_POLLER_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [15:0] ph = 16'h0000;
  logic [15:0] pl = 16'h0009;
  logic [15:0] wh = 16'h0000;
  logic [15:0] wl = 16'h0004;
  logic [15:0] thr0 = 16'h0010;
  logic [23:0] thr1 = 24'h0;
  logic [15:0] val0;
  logic [23:0] val1;
  logic [1:0]  cpu, erri;

  i2c_sensor_poller_if bus0 ();
  i2c_sensor_poller_if bus1 ();

  i2c_sensor_poller #(.DATA_BYTES(2)) dut0 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en0), .i2c(bus0),
    .PeriodCounterPresetH_i(ph), .PeriodCounterPresetL_i(pl),
    .WaitCounterPresetH_i(wh), .WaitCounterPresetL_i(wl),
    .Threshold_i(thr0), .SensorValue_o(val0),
    .CpuIntr_o(cpu[0]), .ErrIntr_o(erri[0])
  );

  i2c_sensor_poller #(.DATA_BYTES(3)) dut1 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en1), .i2c(bus1),
    .PeriodCounterPresetH_i(ph), .PeriodCounterPresetL_i(pl),
    .WaitCounterPresetH_i(wh), .WaitCounterPresetL_i(wl),
    .Threshold_i(thr1), .SensorValue_o(val1),
    .CpuIntr_o(cpu[1]), .ErrIntr_o(erri[1])
  );

  // behavioural master-core state
  logic [1:0]  busy_m = '0;
  logic [1:0]  err_m = '0;
  logic [1:0]  cur_rd = '0;
  logic [7:0]  rx_m [2];
  logic [7:0]  rxf [2][4];
  logic [7:0]  src [2][4];
  logic [23:0] tx_sh [2] = '{24'h0, 24'h0};
  int rptr [2] = '{4, 4};
  int blen [2] = '{0, 0};
  int n_cfg [2] = '{0, 0};
  int n_rd [2] = '{0, 0};
  int n_cfgdone [2] = '{0, 0};
  int tx_ok [2] = '{0, 0};
  int n_fw [2] = '{0, 0};
  int n_pop [2] = '{0, 0};
  int n_cpu [2] = '{0, 0};
  int n_err [2] = '{0, 0};
  int n_inj [2] = '{0, 0};
  int err_tgt [2] = '{0, 0};

  logic [1:0] fw, st, rs, frn;
  logic [7:0] txd [2];
  logic [7:0] rc [2];

  assign fw  = {bus1.fifo_write, bus0.fifo_write};
  assign st  = {bus1.start_process, bus0.start_process};
  assign rs  = {bus1.receive_send_n, bus0.receive_send_n};
  assign frn = {bus1.fifo_read_next, bus0.fifo_read_next};
  assign txd[0] = bus0.tx_data;
  assign txd[1] = bus1.tx_data;
  assign rc[0]  = bus0.read_count;
  assign rc[1]  = bus1.read_count;
  assign bus0.busy    = busy_m[0];
  assign bus1.busy    = busy_m[1];
  assign bus0.error   = err_m[0];
  assign bus1.error   = err_m[1];
  assign bus0.rx_data = rx_m[0];
  assign bus1.rx_data = rx_m[1];

  function automatic int db(input int g);
    return (g != 0) ? 3 : 2;
  endfunction

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      rx_m[g] = 8'h00;
      if (rptr[g] < 4) rx_m[g] = rxf[g][rptr[g]];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fw[g]) begin
        tx_sh[g] <= {tx_sh[g][15:0], txd[g]};
        n_fw[g]  <= n_fw[g] + 1;
      end
      if (frn[g]) begin
        rptr[g]  <= rptr[g] + 1;
        n_pop[g] <= n_pop[g] + 1;
      end
      if (cpu[g])  n_cpu[g] <= n_cpu[g] + 1;
      if (erri[g]) n_err[g] <= n_err[g] + 1;
      if (st[g]) begin
        if (rs[g]) n_rd[g] <= n_rd[g] + 1;
        else       n_cfg[g] <= n_cfg[g] + 1;
        if (tx_sh[g] == (rs[g] ? 24'h900091 : 24'h900320) &&
            int'(rc[g]) == (rs[g] ? db(g) : 0))
          tx_ok[g] <= tx_ok[g] + 1;
        busy_m[g] <= 1'b1;
        err_m[g]  <= 1'b0;
        cur_rd[g] <= rs[g];
        blen[g]   <= int'($urandom_range(1, 4));
      end else if (busy_m[g]) begin
        if (blen[g] == 0) begin
          busy_m[g] <= 1'b0;
          if (cur_rd[g] && n_inj[g] < err_tgt[g]) begin
            err_m[g] <= 1'b1;
            n_inj[g] <= n_inj[g] + 1;
          end else if (cur_rd[g]) begin
            for (int k = 0; k < 4; k++) rxf[g][k] <= src[g][k];
            rptr[g] <= 0;
          end else begin
            n_cfgdone[g] <= n_cfgdone[g] + 1;
          end
        end else begin
          blen[g] <= blen[g] - 1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] refv [2] = '{32'h0, 32'h0};
  int exp_cpu [2] = '{0, 0};
  int exp_err [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] val(input int g);
    return (g != 0) ? {8'h0, val1} : {16'h0, val0};
  endfunction

  function automatic logic [31:0] absd(input logic [31:0] a,
                                       input logic [31:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic load_src(input int g, input logic [31:0] s);
    for (int k = 0; k < 4; k++)
      src[g][k] = (k < db(g)) ? 8'(s >> (8 * (db(g) - 1 - k))) : 8'h00;
  endtask

  task automatic dwell(input int g, output int n);
    n = 0;
    if (g == 0) en0 = 1'b1;
    else        en1 = 1'b1;
    while (!fw[g] && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  task automatic period(input int g, input logic [31:0] s,
                        input logic [31:0] thr, input int nerr);
    int p0, e0, r0, nret;
    bit ok, fail;
    p0 = n_pop[g];
    e0 = n_err[g];
    r0 = n_rd[g];
    load_src(g, s);
    if (g == 0) thr0 = 16'(thr);
    else        thr1 = 24'(thr);
    err_tgt[g] = n_inj[g] + nerr;
    nret = (nerr < RETRIES) ? nerr : RETRIES;
    fail = nerr > RETRIES;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fail ? (n_err[g] > e0) : (n_pop[g] >= p0 + db(g))) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("period_done", 32'(ok), 32'd1);
    tick(3);
    if (fail) exp_err[g]++;
    else if (absd(s, refv[g]) > thr) begin
      refv[g] = s;
      exp_cpu[g]++;
    end
    check("value", val(g), refv[g]);
    check("cpu_pulses", n_cpu[g], exp_cpu[g]);
    check("err_pulses", n_err[g], exp_err[g]);
    check("rd_issues", n_rd[g] - r0, nret + 1);
    check("pops", n_pop[g] - p0, fail ? 0 : db(g));
  endtask

  initial begin
    int n, p0, c0, r0, d0;
    bit ok;
    logic [31:0] s;

    tick(3);
    check("rst_value", val(0), 32'h0);
    check("rst_strobes", {26'h0, fw[0], st[0], rs[0], frn[0], cpu[0],
                          erri[0]}, 32'h0);
    check("rst_rc", 32'(rc[0]), 32'h0);
    check("rst_tx", 32'(txd[0]), 32'h0);
    rst = 1'b0;
    tick(1);

    dwell(0, n);
    check("period_dwell", n, 11);
    period(0, 32'h0C80, 32'h10, 0);
    period(0, 32'h0C88, 32'h10, 0);
    period(0, 32'h0C90, 32'h10, 0);
    period(0, 32'h0C60, 32'h10, 0);
    period(0, 32'h0C61, 32'h0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rs_v, t, off;
      off  = $urandom_range(0, 64);
      rs_v = ($urandom_range(0, 1) != 0) ? refv[0] + off : refv[0] - off;
      rs_v = rs_v & 32'hFFFF;
      t = ($urandom_range(0, 2) == 0) ? absd(rs_v, refv[0])
                                      : $urandom_range(0, 48);
      period(0, rs_v, t, 0);
    end

    period(0, refv[0] ^ 32'h0800, 32'h0, (RETRIES == 0) ? 1 : 2);
    period(0, refv[0] ^ 32'h0400, 32'h0, 0);

    // enable dropped while the read transaction is in flight
    s = refv[0] ^ 32'h4000;
    load_src(0, s);
    thr0 = 16'h0;
    p0 = n_pop[0];
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy_m[0] && cur_rd[0]) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("rdbusy_seen", 32'(ok), 32'd1);
    c0 = n_cfg[0];
    en0 = 1'b0;
    tick(40);
    check("drain_pops", n_pop[0] - p0, 2);
    check("drain_cpu", n_cpu[0], exp_cpu[0]);
    check("drain_value", val(0), refv[0]);
    check("drain_no_new_period", n_cfg[0] - c0, 0);

    // enable dropped during the conversion wait
    dwell(0, n);
    check("dwell_after_drain", n, 11);
    d0 = n_cfgdone[0];
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_cfgdone[0] > d0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("cfg_done_seen", 32'(ok), 32'd1);
    tick(2);
    r0 = n_rd[0];
    en0 = 1'b0;
    tick(40);
    check("conv_abort_no_read", n_rd[0] - r0, 0);

    // reset in the middle of the RX drain
    dwell(0, n);
    check("dwell_after_conv_abort", n, 11);
    load_src(0, refv[0] ^ 32'h2000);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (frn[0]) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("fetch_seen", 32'(ok), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_value", val(0), 32'h0);
    check("midrst_strobes", {26'h0, fw[0], st[0], rs[0], frn[0], cpu[0],
                             erri[0]}, 32'h0);
    check("midrst_rc", 32'(rc[0]), 32'h0);
    check("midrst_tx", 32'(txd[0]), 32'h0);
    en0 = 1'b0;
    rst = 1'b0;
    refv[0] = 32'h0;
    tick(2);
    dwell(0, n);
    check("dwell_after_reset", n, 11);
    period(0, 32'h0001, 32'h0, 0);
    en0 = 1'b0;

    // three-byte instance
    dwell(1, n);
    check("dwell_db3", n, 11);
    period(1, 32'h123456, 32'h0, 0);
    period(1, 32'h123460, 32'h0A, 0);
    en1 = 1'b0;
    tick(40);

    for (int g = 0; g < 2; g++) begin
      check("tx_sequences", tx_ok[g], n_cfg[g] + n_rd[g]);
      check("tx_byte_count", n_fw[g], 3 * (n_cfg[g] + n_rd[g]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_bad);
    $finish;
  end

endmodule
